// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: reset vector, word widths, address alignment helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package inst_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] WORD_BYTES   = 32'd4;

    // Fetches are always word aligned; a bad target is forced down to the word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction memory req/ready bus plus the fetch->decode handshake.
// Latency: n/a (wires only).
// Backpressure: memory via mem_ready, decode via stall.
// master = fetch stage; slave = memory + decode side.
interface inst_fetch_if
    import inst_fetch_pkg::*;
();
    // instruction memory bus
    logic              mem_req;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_ready;
    logic [INST_W-1:0] mem_rdata;
    // toward decode
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   next_pc;
    logic              delay_slot;
    logic              addr_err;
    // back from decode / exception logic
    logic              stall;
    logic              is_jump;
    logic [XLEN-1:0]   jump_pc;
    logic              flush;
    logic [XLEN-1:0]   flush_pc;

    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_rdata,
        output inst_valid, inst, next_pc, delay_slot, addr_err,
        input  stall, is_jump, jump_pc, flush, flush_pc
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_rdata,
        input  inst_valid, inst, next_pc, delay_slot, addr_err,
        output stall, is_jump, jump_pc, flush, flush_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction, MIPS delay-slot jumps, flush.
// Latency: mem_ready -> inst_valid 1 cycle; zero-wait bus gives one instruction every 2 cycles.
// Backpressure: stall holds the instruction in VALID and issues no bus request until accepted.
// Ports: clk, rst_n (async active-low); bus = inst_fetch_if.master (memory bus + decode handshake).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_VALID   = 2'd2,
        S_DISCARD = 2'd3   // flushed while a bus cycle was in flight; wait it out
    } state_t;

    state_t            r_state, w_state_nxt;

    logic [XLEN-1:0]   r_pc;          // address of the fetch in flight / next fetch
    logic              r_pc_err;      // r_pc came from a misaligned target
    logic              r_pend_jump;   // jump accepted, its delay slot not yet accepted
    logic [XLEN-1:0]   r_pend_tgt;
    logic              r_pend_err;
    logic [XLEN-1:0]   r_flush_tgt;   // redirect held while DISCARD drains the bus
    logic              r_flush_err;
    logic [INST_W-1:0] r_inst;
    logic [XLEN-1:0]   r_next_pc;     // inst_pc + 4, kept directly as that is all we need
    logic              r_delay_slot;
    logic              r_addr_err;

    logic              w_capture;
    logic              w_pc_ld;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              w_pc_err_nxt;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_flush_save;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_pc_ld      = 1'b0;
        w_pc_nxt     = r_pc;
        w_pc_err_nxt = r_pc_err;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        w_flush_save = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (bus.flush) begin
                    w_pc_ld      = 1'b1;
                    w_pc_nxt     = word_align(bus.flush_pc);
                    w_pc_err_nxt = is_misaligned(bus.flush_pc);
                    w_pend_clr   = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.flush) begin
                    w_pend_clr = 1'b1;
                    if (bus.mem_ready) begin
                        // bus cycle ends now: drop the word, restart at the redirect
                        w_pc_ld      = 1'b1;
                        w_pc_nxt     = word_align(bus.flush_pc);
                        w_pc_err_nxt = is_misaligned(bus.flush_pc);
                    end else begin
                        w_flush_save = 1'b1;
                        w_state_nxt  = S_DISCARD;
                    end
                end else if (bus.mem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.flush) begin
                    w_pc_ld      = 1'b1;
                    w_pc_nxt     = word_align(bus.flush_pc);
                    w_pc_err_nxt = is_misaligned(bus.flush_pc);
                    w_pend_clr   = 1'b1;
                    w_state_nxt  = S_FETCH;
                end else if (!bus.stall) begin
                    w_pc_ld     = 1'b1;
                    w_state_nxt = S_FETCH;
                    if (r_pend_jump) begin
                        // delay slot accepted: go to the target; a jump in the slot is ignored
                        w_pc_nxt     = r_pend_tgt;
                        w_pc_err_nxt = r_pend_err;
                        w_pend_clr   = 1'b1;
                    end else begin
                        w_pc_nxt     = r_next_pc;
                        w_pc_err_nxt = 1'b0;
                        w_pend_set   = bus.is_jump;
                    end
                end
            end
            S_DISCARD: begin
                if (bus.flush) begin
                    w_pend_clr = 1'b1;
                end
                if (bus.mem_ready) begin
                    w_pc_ld      = 1'b1;
                    w_pc_nxt     = bus.flush ? word_align(bus.flush_pc) : r_flush_tgt;
                    w_pc_err_nxt = bus.flush ? is_misaligned(bus.flush_pc) : r_flush_err;
                    w_state_nxt  = S_FETCH;
                end else if (bus.flush) begin
                    w_flush_save = 1'b1;   // latest redirect wins
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pc_err     <= 1'b0;
            r_pend_jump  <= 1'b0;
            r_pend_tgt   <= '0;
            r_pend_err   <= 1'b0;
            r_flush_tgt  <= '0;
            r_flush_err  <= 1'b0;
            r_inst       <= '0;
            r_next_pc    <= '0;
            r_delay_slot <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_pc_ld) begin
                r_pc     <= w_pc_nxt;
                r_pc_err <= w_pc_err_nxt;
            end
            if (w_capture) begin
                r_inst       <= bus.mem_rdata;
                r_next_pc    <= r_pc + WORD_BYTES;
                r_delay_slot <= r_pend_jump;
                r_addr_err   <= r_pc_err;
            end
            if (w_pend_clr) begin
                r_pend_jump <= 1'b0;
            end else if (w_pend_set) begin
                r_pend_jump <= 1'b1;
                r_pend_tgt  <= word_align(bus.jump_pc);
                r_pend_err  <= is_misaligned(bus.jump_pc);
            end
            if (w_flush_save) begin
                r_flush_tgt <= word_align(bus.flush_pc);
                r_flush_err <= is_misaligned(bus.flush_pc);
            end
        end
    end

    // Outputs decode straight from registers so an async reset drops mem_req at once.
    assign bus.mem_req    = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign bus.mem_addr   = bus.mem_req ? r_pc : '0;
    assign bus.inst_valid = (r_state == S_VALID);
    assign bus.inst       = r_inst;
    assign bus.next_pc    = r_next_pc;
    assign bus.delay_slot = r_delay_slot;
    assign bus.addr_err   = r_addr_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: per-cycle vector table plus a hand-written async-reset sequence.
// Latency: n/a.
// Backpressure: drives stall and mem_ready directly from the vectors.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        is_jump;
        logic [31:0] jump_pc;
        logic        flush;
        logic [31:0] flush_pc;
        logic        ready;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_npc;
        logic        e_ds;
        logic        e_err;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] jpc,
                                input logic fl, input logic [31:0] fpc,
                                input logic rdy, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] ins, input logic [31:0] npc,
                                input logic ds, input logic err);
        vec_t v;
        v.stall = st;  v.is_jump = jp; v.jump_pc = jpc; v.flush = fl; v.flush_pc = fpc;
        v.ready = rdy; v.rdata = rd;
        v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_inst = ins; v.e_npc = npc;
        v.e_ds = ds;   v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ins, input logic [31:0] npc,
                            input logic ds, input logic err);
        chk({tag, " mem_req"},    {31'd0, bus.mem_req},    {31'd0, req});
        chk({tag, " mem_addr"},   bus.mem_addr,            addr);
        chk({tag, " inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, vld});
        chk({tag, " inst"},       bus.inst,                ins);
        chk({tag, " next_pc"},    bus.next_pc,             npc);
        chk({tag, " delay_slot"}, {31'd0, bus.delay_slot}, {31'd0, ds});
        chk({tag, " addr_err"},   {31'd0, bus.addr_err},   {31'd0, err});
    endtask

    task automatic drive(input vec_t v);
        bus.stall     = v.stall;
        bus.is_jump   = v.is_jump;
        bus.jump_pc   = v.jump_pc;
        bus.flush     = v.flush;
        bus.flush_pc  = v.flush_pc;
        bus.mem_ready = v.ready;
        bus.mem_rdata = v.rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // boot, zero-wait fetches
        vecs[0]  = mk(0,0,0,0,0, 1,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0,0);
        vecs[1]  = mk(0,0,0,0,0, 1,32'h11111111, 1,32'hBFC00000, 0,32'h0,        32'h0,        0,0);
        vecs[2]  = mk(0,0,0,0,0, 1,32'h0,        0,32'h0,        1,32'h11111111, 32'hBFC00004, 0,0);
        vecs[3]  = mk(0,0,0,0,0, 1,32'h22222222, 1,32'hBFC00004, 0,32'h11111111, 32'hBFC00004, 0,0);
        vecs[4]  = mk(0,0,0,0,0, 1,32'h0,        0,32'h0,        1,32'h22222222, 32'hBFC00008, 0,0);
        // three wait states, address held
        vecs[5]  = mk(0,0,0,0,0, 0,32'h0,        1,32'hBFC00008, 0,32'h22222222, 32'hBFC00008, 0,0);
        vecs[6]  = mk(0,0,0,0,0, 0,32'h0,        1,32'hBFC00008, 0,32'h22222222, 32'hBFC00008, 0,0);
        vecs[7]  = mk(0,0,0,0,0, 0,32'h0,        1,32'hBFC00008, 0,32'h22222222, 32'hBFC00008, 0,0);
        vecs[8]  = mk(0,0,0,0,0, 1,32'h33333333, 1,32'hBFC00008, 0,32'h22222222, 32'hBFC00008, 0,0);
        // stall five cycles, then accept
        vecs[9]  = mk(1,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[10] = mk(1,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[11] = mk(1,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[12] = mk(1,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[13] = mk(1,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[14] = mk(0,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h33333333, 32'hBFC0000C, 0,0);
        // flush with ready in the same cycle: word dropped, refetch at 80000010
        vecs[15] = mk(0,0,0,1,32'h80000010, 1,32'hDEADDEAD, 1,32'hBFC0000C, 0,32'h33333333, 32'hBFC0000C, 0,0);
        vecs[16] = mk(0,0,0,0,0, 1,32'h44444444, 1,32'h80000010, 0,32'h33333333, 32'hBFC0000C, 0,0);
        // jump at 80000010 -> slot 80000014 -> target 80000100
        vecs[17] = mk(0,1,32'h80000100,0,0, 0,32'h0, 0,32'h0,        1,32'h44444444, 32'h80000014, 0,0);
        vecs[18] = mk(0,0,0,0,0, 1,32'h55555555, 1,32'h80000014, 0,32'h44444444, 32'h80000014, 0,0);
        vecs[19] = mk(0,1,32'h12345678,0,0, 0,32'h0, 0,32'h0,        1,32'h55555555, 32'h80000018, 1,0);
        vecs[20] = mk(0,0,0,0,0, 1,32'h66666666, 1,32'h80000100, 0,32'h55555555, 32'h80000018, 1,0);
        // misaligned jump target 80000102 -> fetch 80000100 with addr_err
        vecs[21] = mk(0,1,32'h80000102,0,0, 0,32'h0, 0,32'h0,        1,32'h66666666, 32'h80000104, 0,0);
        vecs[22] = mk(0,0,0,0,0, 1,32'h77777777, 1,32'h80000104, 0,32'h66666666, 32'h80000104, 0,0);
        vecs[23] = mk(0,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h77777777, 32'h80000108, 1,0);
        vecs[24] = mk(0,0,0,0,0, 1,32'h88888888, 1,32'h80000100, 0,32'h77777777, 32'h80000108, 1,0);
        // jump pending, flush mid-FETCH with ready low, second flush in DISCARD wins
        vecs[25] = mk(0,1,32'h80000300,0,0, 0,32'h0, 0,32'h0,        1,32'h88888888, 32'h80000104, 0,1);
        vecs[26] = mk(0,0,0,1,32'h80000400, 0,32'h0, 1,32'h80000104, 0,32'h88888888, 32'h80000104, 0,1);
        vecs[27] = mk(0,0,0,0,0, 0,32'h0,        1,32'h80000104, 0,32'h88888888, 32'h80000104, 0,1);
        vecs[28] = mk(0,0,0,1,32'h80000180, 0,32'h0, 1,32'h80000104, 0,32'h88888888, 32'h80000104, 0,1);
        vecs[29] = mk(0,0,0,0,0, 1,32'hBADBAD00, 1,32'h80000104, 0,32'h88888888, 32'h80000104, 0,1);
        vecs[30] = mk(0,0,0,0,0, 1,32'h99999999, 1,32'h80000180, 0,32'h88888888, 32'h80000104, 0,1);
        // pend_jump was cleared: accept goes sequential, not to 80000300
        vecs[31] = mk(0,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'h99999999, 32'h80000184, 0,0);
        vecs[32] = mk(0,0,0,0,0, 1,32'hAAAAAAAA, 1,32'h80000184, 0,32'h99999999, 32'h80000184, 0,0);
        // flush beats is_jump in VALID; next_pc wraps FFFFFFFC -> 0
        vecs[33] = mk(0,1,32'h80000500,1,32'hFFFFFFFC, 0,32'h0, 0,32'h0, 1,32'hAAAAAAAA, 32'h80000188, 0,0);
        vecs[34] = mk(0,0,0,0,0, 1,32'hBBBBBBBB, 1,32'hFFFFFFFC, 0,32'hAAAAAAAA, 32'h80000188, 0,0);
        vecs[35] = mk(0,0,0,0,0, 0,32'h0,        0,32'h0,        1,32'hBBBBBBBB, 32'h00000000, 0,0);
        vecs[36] = mk(0,0,0,0,0, 0,32'h0,        1,32'h00000000, 0,32'hBBBBBBBB, 32'h00000000, 0,0);
        vecs[37] = mk(0,0,0,0,0, 0,32'h0,        1,32'h00000000, 0,32'hBBBBBBBB, 32'h00000000, 0,0);

        drive(mk(0,0,0,0,0, 0,32'h0, 0,32'h0,0,32'h0,32'h0,0,0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                     vecs[i].e_inst, vecs[i].e_npc, vecs[i].e_ds, vecs[i].e_err);
            drive(vecs[i]);
            @(negedge clk);
        end

        // async reset in the middle of a FETCH (ready low): request must drop at once
        bus.mem_ready = 1'b0;
        chk("pre-reset mem_req", {31'd0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async-reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_outs("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("refetch", 1'b1, 32'hBFC00000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk_outs("refetch-valid", 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 32'hBFC00004, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
